// File: rtl/mc_controller.sv
// mc_controller: multi-cycle control FSM for the MIPS datapath.
// Fetches over the imem handshake, decodes the latched IR and sequences the write strobes.
module mc_controller #(
    parameter int CNT_W         = 32,
    parameter int FETCH_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             imem_rdy,
    input  logic [31:0]      instr,
    output logic             imem_req,
    output logic             ir_we,
    output logic             pc_we,
    output logic             reg_write,
    output logic [3:0]       alu_op,
    output logic             alu_srca,
    output logic             alu_srcb,
    output logic             reg_dst,
    output logic             ext_op,
    output logic             jump,
    output logic             jr,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired,
    output logic [1:0]       fault
);

    localparam int TW = $clog2(FETCH_TIMEOUT);
    localparam logic [TW-1:0] CNT_LAST = TW'(FETCH_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SLL = 4'b1000;
    localparam logic [3:0] ALU_SRL = 4'b1001;

    state_t            state_q;
    logic [31:0]       ir_q;
    logic [TW-1:0]     cnt_q;
    logic [CNT_W-1:0]  retired_q;
    logic [1:0]        fault_q;

    logic              dec_legal;
    logic              dec_j;
    logic              dec_jr;
    logic [3:0]        dec_alu_op;
    logic              dec_srca;
    logic              dec_srcb;
    logic              dec_reg_dst;
    logic              dec_ext;

    // Register and immediate fields of IR belong to the datapath, not to control.
    logic              unused_ir;
    assign unused_ir = ^ir_q[25:6];

    always_comb begin
        dec_legal   = 1'b0;
        dec_j       = 1'b0;
        dec_jr      = 1'b0;
        dec_alu_op  = ALU_AND;
        dec_srca    = 1'b0;
        dec_srcb    = 1'b0;
        dec_reg_dst = 1'b0;
        dec_ext     = 1'b0;
        case (ir_q[31:26])
            6'b000000: begin
                dec_reg_dst = 1'b1;
                case (ir_q[5:0])
                    6'b100000: begin dec_legal = 1'b1; dec_alu_op = ALU_ADD; end
                    6'b100010: begin dec_legal = 1'b1; dec_alu_op = ALU_SUB; end
                    6'b100100: begin dec_legal = 1'b1; dec_alu_op = ALU_AND; end
                    6'b100101: begin dec_legal = 1'b1; dec_alu_op = ALU_OR;  end
                    6'b101010: begin dec_legal = 1'b1; dec_alu_op = ALU_SLT; end
                    6'b000000: begin
                        dec_legal  = 1'b1;
                        dec_alu_op = ALU_SLL;
                        dec_srca   = 1'b1;
                        dec_srcb   = 1'b1;
                    end
                    6'b000010: begin
                        dec_legal  = 1'b1;
                        dec_alu_op = ALU_SRL;
                        dec_srca   = 1'b1;
                        dec_srcb   = 1'b1;
                    end
                    6'b001000: begin dec_legal = 1'b1; dec_jr = 1'b1; end
                    default: ;
                endcase
            end
            6'b001000: begin
                dec_legal  = 1'b1;
                dec_alu_op = ALU_ADD;
                dec_srcb   = 1'b1;
                dec_ext    = 1'b1;
            end
            6'b001100: begin dec_legal = 1'b1; dec_alu_op = ALU_AND; dec_srcb = 1'b1; end
            6'b001101: begin dec_legal = 1'b1; dec_alu_op = ALU_OR;  dec_srcb = 1'b1; end
            6'b000010: begin dec_legal = 1'b1; dec_j = 1'b1; end
            default: ;
        endcase
    end

    // The fetch counter only advances on stalled FETCH cycles; TRAP is sticky until reset.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q   <= S_IDLE;
            ir_q      <= '0;
            cnt_q     <= '0;
            retired_q <= '0;
            fault_q   <= 2'b00;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (run) state_q <= S_FETCH;
                end
                S_FETCH: begin
                    if (imem_rdy) begin
                        ir_q    <= instr;
                        cnt_q   <= '0;
                        state_q <= S_DECODE;
                    end else if (cnt_q == CNT_LAST) begin
                        cnt_q   <= '0;
                        fault_q <= 2'b10;
                        state_q <= S_TRAP;
                    end else begin
                        cnt_q <= cnt_q + TW'(1);
                    end
                end
                S_DECODE: begin
                    if (!dec_legal) begin
                        fault_q <= 2'b01;
                        state_q <= S_TRAP;
                    end else if (dec_j || dec_jr) begin
                        retired_q <= retired_q + CNT_W'(1);
                        state_q   <= run ? S_FETCH : S_IDLE;
                    end else begin
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: state_q <= S_WB;
                S_WB: begin
                    retired_q <= retired_q + CNT_W'(1);
                    state_q   <= run ? S_FETCH : S_IDLE;
                end
                S_TRAP: ;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Outputs follow the registered state and IR; ir_we alone looks at imem_rdy directly.
    always_comb begin
        imem_req  = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        reg_write = 1'b0;
        alu_op    = 4'b0000;
        alu_srca  = 1'b0;
        alu_srcb  = 1'b0;
        reg_dst   = 1'b0;
        ext_op    = 1'b0;
        jump      = 1'b0;
        jr        = 1'b0;
        if (!rst_n) begin
            case (state_q)
                S_FETCH: begin
                    imem_req = 1'b1;
                    ir_we    = imem_rdy;
                end
                S_DECODE: begin
                    if (dec_legal) begin
                        pc_we = dec_j | dec_jr;
                        jump  = dec_j;
                        jr    = dec_jr;
                    end
                end
                S_EXEC, S_WB: begin
                    alu_op    = dec_alu_op;
                    alu_srca  = dec_srca;
                    alu_srcb  = dec_srcb;
                    reg_dst   = dec_reg_dst;
                    ext_op    = dec_ext;
                    reg_write = (state_q == S_WB);
                    pc_we     = (state_q == S_WB);
                end
                default: ;
            endcase
        end
    end

    assign state   = state_q;
    assign retired = retired_q;
    assign fault   = fault_q;

endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: directed and randomized checks of mc_controller against a
// mnemonic-level model of the instruction set and its cycle counts.
module tb_mc_controller;

    localparam int TIMEOUT = 16;

    logic        clk;
    logic        rst_n;
    logic        run;
    logic        imem_rdy;
    logic [31:0] instr;
    logic        imem_req;
    logic        ir_we;
    logic        pc_we;
    logic        reg_write;
    logic [3:0]  alu_op;
    logic        alu_srca;
    logic        alu_srcb;
    logic        reg_dst;
    logic        ext_op;
    logic        jump;
    logic        jr;
    logic [2:0]  state;
    logic [31:0] retired;
    logic [1:0]  fault;

    int checks   = 0;
    int failures = 0;

    wire [5:0] strobes = {imem_req, ir_we, pc_we, reg_write, jump, jr};
    wire [7:0] ctrls   = {alu_op, alu_srca, alu_srcb, reg_dst, ext_op};

    mc_controller #(.CNT_W(32), .FETCH_TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .imem_rdy(imem_rdy), .instr(instr),
        .imem_req(imem_req), .ir_we(ir_we), .pc_we(pc_we), .reg_write(reg_write),
        .alu_op(alu_op), .alu_srca(alu_srca), .alu_srcb(alu_srcb), .reg_dst(reg_dst),
        .ext_op(ext_op), .jump(jump), .jr(jr), .state(state), .retired(retired), .fault(fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum logic [3:0] {
        M_ADD, M_SUB, M_AND, M_OR, M_SLT, M_SLL, M_SRL, M_JR,
        M_ADDI, M_ANDI, M_ORI, M_J, M_ILL
    } mnem_t;

    function automatic mnem_t classify(input logic [31:0] w);
        mnem_t m;
        m = M_ILL;
        if (w[31:26] == 6'h00) begin
            case (w[5:0])
                6'h20: m = M_ADD;
                6'h22: m = M_SUB;
                6'h24: m = M_AND;
                6'h25: m = M_OR;
                6'h2a: m = M_SLT;
                6'h00: m = M_SLL;
                6'h02: m = M_SRL;
                6'h08: m = M_JR;
                default: m = M_ILL;
            endcase
        end else begin
            case (w[31:26])
                6'h08: m = M_ADDI;
                6'h0c: m = M_ANDI;
                6'h0d: m = M_ORI;
                6'h02: m = M_J;
                default: m = M_ILL;
            endcase
        end
        return m;
    endfunction

    // {alu_op, srca, srcb, reg_dst, ext} expected during EXEC and WB.
    function automatic logic [7:0] ctrl_of(input mnem_t m);
        case (m)
            M_ADD:  return {4'b0010, 4'b0010};
            M_SUB:  return {4'b0110, 4'b0010};
            M_AND:  return {4'b0000, 4'b0010};
            M_OR:   return {4'b0001, 4'b0010};
            M_SLT:  return {4'b0111, 4'b0010};
            M_SLL:  return {4'b1000, 4'b1110};
            M_SRL:  return {4'b1001, 4'b1110};
            M_ADDI: return {4'b0010, 4'b0101};
            M_ANDI: return {4'b0000, 4'b0100};
            M_ORI:  return {4'b0001, 4'b0100};
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [31:0] build(input mnem_t m);
        logic [31:0] w;
        w = $urandom;
        case (m)
            M_ADD:  begin w[31:26] = 6'h00; w[5:0] = 6'h20; end
            M_SUB:  begin w[31:26] = 6'h00; w[5:0] = 6'h22; end
            M_AND:  begin w[31:26] = 6'h00; w[5:0] = 6'h24; end
            M_OR:   begin w[31:26] = 6'h00; w[5:0] = 6'h25; end
            M_SLT:  begin w[31:26] = 6'h00; w[5:0] = 6'h2a; end
            M_SLL:  begin w[31:26] = 6'h00; w[5:0] = 6'h00; end
            M_SRL:  begin w[31:26] = 6'h00; w[5:0] = 6'h02; end
            M_JR:   begin w[31:26] = 6'h00; w[5:0] = 6'h08; end
            M_ADDI: w[31:26] = 6'h08;
            M_ANDI: w[31:26] = 6'h0c;
            M_ORI:  w[31:26] = 6'h0d;
            M_J:    w[31:26] = 6'h02;
            default: begin
                for (int t = 0; t < 64; t++) begin
                    w = $urandom;
                    if ($urandom_range(0, 1) == 1) w[31:26] = 6'h00;
                    if (classify(w) == M_ILL) break;
                end
                if (classify(w) != M_ILL) w = 32'hFC000000;
            end
        endcase
        return w;
    endfunction

    task automatic applyStimulus(input logic r, input logic ru, input logic rdy, input logic [31:0] w);
        @(negedge clk);
        rst_n    = r;
        run      = ru;
        imem_rdy = rdy;
        instr    = w;
        #1;
    endtask

    task automatic do_reset();
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_reset();
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h20080005);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h20080005);
        checks++; if (state !== 3'd0) begin failures++; $display("[TB] FAIL reset_state: got %0d want 0", state); end
        checks++; if (retired !== 32'd0) begin failures++; $display("[TB] FAIL reset_retired: got %0d want 0", retired); end
        checks++; if (fault !== 2'b00) begin failures++; $display("[TB] FAIL reset_fault: got %0b want 00", fault); end
        checks++; if (strobes !== 6'b0) begin failures++; $display("[TB] FAIL reset_strobes: got %b want 000000", strobes); end
        checks++; if (ctrls !== 8'b0) begin failures++; $display("[TB] FAIL reset_ctrls: got %b want 00000000", ctrls); end
        // Reset asserted while FETCH sees imem_rdy: no ir_we that cycle.
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h20080005);
        checks++; if (strobes !== 6'b0) begin failures++; $display("[TB] FAIL reset_in_fetch_strobes: got %b want 000000", strobes); end
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h20080005);
        checks++; if (state !== 3'd0) begin failures++; $display("[TB] FAIL reset_in_fetch_state: got %0d want 0", state); end
        // Reset asserted during WB: no reg_write/pc_we, nothing retired.
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h20080005);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checks++; if (state !== 3'd4) begin failures++; $display("[TB] FAIL reset_in_wb_pre_state: got %0d want 4", state); end
        checks++; if (strobes !== 6'b0) begin failures++; $display("[TB] FAIL reset_in_wb_strobes: got %b want 000000", strobes); end
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checks++; if (state !== 3'd0) begin failures++; $display("[TB] FAIL reset_in_wb_state: got %0d want 0", state); end
        checks++; if (retired !== 32'd0) begin failures++; $display("[TB] FAIL reset_in_wb_retired: got %0d want 0", retired); end
    endtask

    task automatic test_addi();
        logic [2:0] expState [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd1};
        do_reset();
        for (int s = 0; s < 6; s++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 32'h20080005);
            checks++; if (state !== expState[s]) begin failures++; $display("[TB] FAIL addi_state step %0d: got %0d want %0d", s, state, expState[s]); end
            if (s == 1) begin
                checks++; if (strobes !== 6'b110000) begin failures++; $display("[TB] FAIL addi_fetch_strobes: got %b want 110000", strobes); end
            end
            if (s == 3) begin
                checks++; if (strobes !== 6'b000000) begin failures++; $display("[TB] FAIL addi_exec_strobes: got %b want 000000", strobes); end
            end
            if (s == 4) begin
                checks++; if (strobes !== 6'b001100) begin failures++; $display("[TB] FAIL addi_wb_strobes: got %b want 001100", strobes); end
                checks++; if (ctrls !== 8'b0010_0101) begin failures++; $display("[TB] FAIL addi_wb_ctrls: got %b want 00100101", ctrls); end
            end
            if (s == 5) begin
                checks++; if (retired !== 32'd1) begin failures++; $display("[TB] FAIL addi_retired: got %0d want 1", retired); end
            end
        end
    endtask

    task automatic test_jump();
        do_reset();
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h08000010);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h08000010);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h08000010);
        checks++; if (state !== 3'd2) begin failures++; $display("[TB] FAIL j_decode_state: got %0d want 2", state); end
        checks++; if (strobes !== 6'b001010) begin failures++; $display("[TB] FAIL j_decode_strobes: got %b want 001010", strobes); end
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checks++; if (state !== 3'd1) begin failures++; $display("[TB] FAIL j_next_state: got %0d want 1", state); end
        checks++; if (retired !== 32'd1) begin failures++; $display("[TB] FAIL j_retired: got %0d want 1", retired); end
    endtask

    task automatic test_shift();
        do_reset();
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h00084080);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h00084080);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checks++; if (ctrls !== 8'b0) begin failures++; $display("[TB] FAIL sll_decode_ctrls: got %b want 00000000", ctrls); end
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checks++; if (ctrls !== 8'b1000_1110) begin failures++; $display("[TB] FAIL sll_exec_ctrls: got %b want 10001110", ctrls); end
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checks++; if (ctrls !== 8'b1000_1110) begin failures++; $display("[TB] FAIL sll_wb_ctrls: got %b want 10001110", ctrls); end
        checks++; if (strobes !== 6'b001100) begin failures++; $display("[TB] FAIL sll_wb_strobes: got %b want 001100", strobes); end
    endtask

    task automatic test_illegal();
        do_reset();
        applyStimulus(1'b0, 1'b1, 1'b1, 32'hFC000000);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'hFC000000);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h0);
        checks++; if (strobes !== 6'b0) begin failures++; $display("[TB] FAIL ill_decode_strobes: got %b want 000000", strobes); end
        for (int s = 0; s < 3; s++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 32'h20080005);
            checks++; if (state !== 3'd5) begin failures++; $display("[TB] FAIL ill_trap_state: got %0d want 5", state); end
            checks++; if (fault !== 2'b01) begin failures++; $display("[TB] FAIL ill_fault: got %b want 01", fault); end
            checks++; if (strobes !== 6'b0) begin failures++; $display("[TB] FAIL ill_trap_strobes: got %b want 000000", strobes); end
        end
        checks++; if (retired !== 32'd0) begin failures++; $display("[TB] FAIL ill_retired: got %0d want 0", retired); end
        do_reset();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checks++; if (state !== 3'd0) begin failures++; $display("[TB] FAIL ill_reset_state: got %0d want 0", state); end
        checks++; if (fault !== 2'b00) begin failures++; $display("[TB] FAIL ill_reset_fault: got %b want 00", fault); end
    endtask

    task automatic test_timeout();
        do_reset();
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        for (int k = 0; k < TIMEOUT; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 32'h20080005);
            checks++; if (strobes !== 6'b100000) begin failures++; $display("[TB] FAIL to_wait_strobes cycle %0d: got %b want 100000", k, strobes); end
        end
        for (int s = 0; s < 2; s++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 32'h20080005);
            checks++; if (state !== 3'd5) begin failures++; $display("[TB] FAIL to_state: got %0d want 5", state); end
            checks++; if (fault !== 2'b10) begin failures++; $display("[TB] FAIL to_fault: got %b want 10", fault); end
            checks++; if (strobes !== 6'b0) begin failures++; $display("[TB] FAIL to_trap_strobes: got %b want 000000", strobes); end
        end
        // One stall fewer than the limit: the handshake still completes.
        do_reset();
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        for (int k = 0; k < TIMEOUT - 1; k++) applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h20080005);
        checks++; if (strobes !== 6'b110000) begin failures++; $display("[TB] FAIL to_edge_fetch_strobes: got %b want 110000", strobes); end
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checks++; if (state !== 3'd2) begin failures++; $display("[TB] FAIL to_edge_state: got %0d want 2", state); end
        checks++; if (fault !== 2'b00) begin failures++; $display("[TB] FAIL to_edge_fault: got %b want 00", fault); end
    endtask

    task automatic test_run_drop();
        do_reset();
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h20080005);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h20080005);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checks++; if (state !== 3'd3) begin failures++; $display("[TB] FAIL rd_exec_state: got %0d want 3", state); end
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checks++; if (reg_write !== 1'b1) begin failures++; $display("[TB] FAIL rd_wb_reg_write: got %b want 1", reg_write); end
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0);
        checks++; if (state !== 3'd0) begin failures++; $display("[TB] FAIL rd_idle_state: got %0d want 0", state); end
        checks++; if (retired !== 32'd1) begin failures++; $display("[TB] FAIL rd_retired: got %0d want 1", retired); end
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h20080005);
        checks++; if (state !== 3'd0) begin failures++; $display("[TB] FAIL rd_idle_hold: got %0d want 0", state); end
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h20080005);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checks++; if (state !== 3'd3) begin failures++; $display("[TB] FAIL rd_exec2_state: got %0d want 3", state); end
        checks++; if (reg_write !== 1'b0) begin failures++; $display("[TB] FAIL rd_exec2_reg_write: got %b want 0", reg_write); end
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checks++; if (state !== 3'd0) begin failures++; $display("[TB] FAIL rd_rst_state: got %0d want 0", state); end
        checks++; if (reg_write !== 1'b0) begin failures++; $display("[TB] FAIL rd_rst_reg_write: got %b want 0", reg_write); end
        checks++; if (retired !== 32'd0) begin failures++; $display("[TB] FAIL rd_rst_retired: got %0d want 0", retired); end
    endtask

    // Random instruction stream with random fetch stalls and run toggling.
    task automatic test_random();
        logic [31:0] expRet;
        logic [31:0] w;
        logic [7:0]  ec;
        logic [5:0]  es;
        logic        endRun;
        mnem_t       m;
        int          stalls;
        do_reset();
        expRet = '0;
        applyStimulus(1'b0, 1'b1, 1'($urandom), $urandom);
        checks++; if (state !== 3'd0) begin failures++; $display("[TB] FAIL rnd_start_state: got %0d want 0", state); end
        for (int n = 0; n < 400; n++) begin
            m      = ($urandom_range(0, 9) == 0) ? M_ILL : mnem_t'($urandom_range(0, 11));
            w      = build(m);
            ec     = ctrl_of(m);
            stalls = $urandom_range(0, 3);
            for (int k = 0; k < stalls; k++) begin
                applyStimulus(1'b0, 1'b1, 1'b0, $urandom);
                checks++; if (state !== 3'd1) begin failures++; $display("[TB] FAIL rnd_stall_state #%0d: got %0d want 1", n, state); end
                checks++; if (strobes !== 6'b100000) begin failures++; $display("[TB] FAIL rnd_stall_strobes #%0d: got %b want 100000", n, strobes); end
            end
            applyStimulus(1'b0, 1'b1, 1'b1, w);
            checks++; if (state !== 3'd1) begin failures++; $display("[TB] FAIL rnd_fetch_state #%0d: got %0d want 1", n, state); end
            checks++; if (strobes !== 6'b110000) begin failures++; $display("[TB] FAIL rnd_fetch_strobes #%0d: got %b want 110000", n, strobes); end
            checks++; if (retired !== expRet) begin failures++; $display("[TB] FAIL rnd_retired #%0d: got %0d want %0d", n, retired, expRet); end
            endRun = 1'($urandom_range(0, 1));
            applyStimulus(1'b0, endRun, 1'($urandom), $urandom);
            checks++; if (state !== 3'd2) begin failures++; $display("[TB] FAIL rnd_decode_state #%0d %h: got %0d want 2", n, w, state); end
            checks++; if (ctrls !== 8'h00) begin failures++; $display("[TB] FAIL rnd_decode_ctrls #%0d %h: got %b want 0", n, w, ctrls); end
            if (m == M_ILL) begin
                checks++; if (strobes !== 6'b0) begin failures++; $display("[TB] FAIL rnd_ill_strobes #%0d %h: got %b want 000000", n, w, strobes); end
                applyStimulus(1'b0, 1'b1, 1'b1, $urandom);
                checks++; if (state !== 3'd5) begin failures++; $display("[TB] FAIL rnd_ill_state #%0d %h: got %0d want 5", n, w, state); end
                checks++; if (fault !== 2'b01) begin failures++; $display("[TB] FAIL rnd_ill_fault #%0d %h: got %b want 01", n, w, fault); end
                checks++; if (retired !== expRet) begin failures++; $display("[TB] FAIL rnd_ill_retired #%0d: got %0d want %0d", n, retired, expRet); end
                do_reset();
                expRet = '0;
                applyStimulus(1'b0, 1'b1, 1'($urandom), $urandom);
                checks++; if (state !== 3'd0) begin failures++; $display("[TB] FAIL rnd_ill_reset_state #%0d: got %0d want 0", n, state); end
            end else if (m == M_J || m == M_JR) begin
                es = {4'b0010, (m == M_J), (m == M_JR)};
                checks++; if (strobes !== es) begin failures++; $display("[TB] FAIL rnd_jump_strobes #%0d %h: got %b want %b", n, w, strobes, es); end
                expRet = expRet + 32'd1;
            end else begin
                checks++; if (strobes !== 6'b0) begin failures++; $display("[TB] FAIL rnd_decode_strobes #%0d %h: got %b want 000000", n, w, strobes); end
                applyStimulus(1'b0, 1'($urandom), 1'($urandom), $urandom);
                checks++; if (state !== 3'd3) begin failures++; $display("[TB] FAIL rnd_exec_state #%0d %h: got %0d want 3", n, w, state); end
                checks++; if (strobes !== 6'b0) begin failures++; $display("[TB] FAIL rnd_exec_strobes #%0d %h: got %b want 000000", n, w, strobes); end
                checks++; if (ctrls !== ec) begin failures++; $display("[TB] FAIL rnd_exec_ctrls #%0d %h: got %b want %b", n, w, ctrls, ec); end
                applyStimulus(1'b0, endRun, 1'($urandom), $urandom);
                checks++; if (state !== 3'd4) begin failures++; $display("[TB] FAIL rnd_wb_state #%0d %h: got %0d want 4", n, w, state); end
                checks++; if (strobes !== 6'b001100) begin failures++; $display("[TB] FAIL rnd_wb_strobes #%0d %h: got %b want 001100", n, w, strobes); end
                checks++; if (ctrls !== ec) begin failures++; $display("[TB] FAIL rnd_wb_ctrls #%0d %h: got %b want %b", n, w, ctrls, ec); end
                expRet = expRet + 32'd1;
            end
            if (m != M_ILL && !endRun) begin
                applyStimulus(1'b0, 1'b1, 1'($urandom), $urandom);
                checks++; if (state !== 3'd0) begin failures++; $display("[TB] FAIL rnd_idle_state #%0d: got %0d want 0", n, state); end
                checks++; if (retired !== expRet) begin failures++; $display("[TB] FAIL rnd_idle_retired #%0d: got %0d want %0d", n, retired, expRet); end
            end
        end
    endtask

    initial begin
        rst_n    = 1'b1;
        run      = 1'b0;
        imem_rdy = 1'b0;
        instr    = 32'h0;
        test_reset();
        test_addi();
        test_jump();
        test_shift();
        test_illegal();
        test_timeout();
        test_run_drop();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
